// File: rtl/tickgen_multi.sv
// tickgen_multi -- bank of independent programmable tick / square-wave generators.
// Latency: tick is combinational from channel state; a divisor update lands at the
//   next tick of an enabled channel, or on the next edge of a disabled channel.
// Backpressure: cfg_ready drops while the addressed channel holds an unapplied update.
// Ports: clk, rst_n (async, active-low); en[CHANNELS] per-channel run enables;
//   sync_clr clears all phases; cfg_valid/cfg_ready/cfg_ch/cfg_div divisor update;
//   tick[CHANNELS] one-cycle strobe per period; sq[CHANNELS] toggles on every tick.
module tickgen_multi #(
  parameter  int CHANNELS    = 4,
  parameter  int DIV_W       = 26,
  parameter  int DEFAULT_DIV = 5_000_000,
  localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] en,
  input  logic                sync_clr,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [DIV_W-1:0]    cfg_div,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] sq
);

  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  logic [CHANNELS-1:0][DIV_W-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0][DIV_W-1:0] div_act_q, div_act_d;
  logic [CHANNELS-1:0][DIV_W-1:0] div_shd_q, div_shd_d;
  logic [CHANNELS-1:0]            pend_q, pend_d;
  logic [CHANNELS-1:0]            sq_q, sq_d;

  logic [CHANNELS-1:0][DIV_W-1:0] term_w;
  logic [CHANNELS-1:0]            tick_w;
  logic [CHANNELS-1:0]            xfer_w;
  logic                           cfg_ready_w;

  // Terminal count is div_eff-1; a programmed divisor of 0 behaves as 1.
  // The rst_n term keeps tick low during reset even when DEFAULT_DIV <= 1.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      term_w[i] = (div_act_q[i] == '0) ? '0 : div_act_q[i] - ONE;
      tick_w[i] = rst_n & en[i] & (cnt_q[i] == term_w[i]);
    end
  end

  // Out-of-range channel indices match nothing, so they are always ready and
  // the transfer is silently dropped.
  always_comb begin
    cfg_ready_w = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready_w = ~pend_q[i];
      end
    end
    for (int i = 0; i < CHANNELS; i++) begin
      xfer_w[i] = cfg_valid & cfg_ready_w & (cfg_ch == CH_W'(i));
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    div_act_d = div_act_q;
    div_shd_d = div_shd_q;
    pend_d    = pend_q;
    sq_d      = sq_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sync_clr || !en[i]) begin
        // Phase is being discarded, so any staged divisor can land right away
        // and a new one can go straight to the active register.
        cnt_d[i] = '0;
        sq_d[i]  = 1'b0;
        if (pend_q[i]) begin
          div_act_d[i] = div_shd_q[i];
          pend_d[i]    = 1'b0;
        end
        if (xfer_w[i]) begin
          div_act_d[i] = cfg_div;
        end
      end else begin
        if (tick_w[i]) begin
          cnt_d[i] = '0;
          sq_d[i]  = ~sq_q[i];
          if (pend_q[i]) begin
            div_act_d[i] = div_shd_q[i];
            pend_d[i]    = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + ONE;
        end
        // A running channel stages the update so the current period completes
        // untouched. xfer implies pend_q=0, so this never collides with the
        // apply above.
        if (xfer_w[i]) begin
          div_shd_d[i] = cfg_div;
          pend_d[i]    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      div_act_q <= {CHANNELS{RST_DIV}};
      div_shd_q <= {CHANNELS{RST_DIV}};
      pend_q    <= '0;
      sq_q      <= '0;
    end else begin
      cnt_q     <= cnt_d;
      div_act_q <= div_act_d;
      div_shd_q <= div_shd_d;
      pend_q    <= pend_d;
      sq_q      <= sq_d;
    end
  end

  assign tick      = tick_w;
  assign sq        = sq_q;
  assign cfg_ready = cfg_ready_w;

endmodule

// File: tb/tb_tickgen_multi.sv
// tb_tickgen_multi -- scoreboard bench for tickgen_multi.
// Cycle N is the interval between the (N-1)th and Nth rising edge after reset release;
// inputs change 1 time unit after an edge and outputs are sampled 5 units after it.
// Expected {cfg_ready, tick, sq} per cycle are queued up front and popped per cycle.
module tb_tickgen_multi;

  logic       clk;
  logic       rst_n;

  logic [1:0] en;
  logic       sync_clr;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [0:0] cfg_ch;
  logic [7:0] cfg_div;
  logic [1:0] tick;
  logic [1:0] sq;

  logic [2:0] en3;
  logic       sync_clr3;
  logic       cfg_valid3;
  logic       cfg_ready3;
  logic [1:0] cfg_ch3;
  logic [7:0] cfg_div3;
  logic [2:0] tick3;
  logic [2:0] sq3;

  int         vectors;
  int         miscompares;
  int         cyc;

  logic [4:0] exp_q[$];   // {cfg_ready, tick[1:0], sq[1:0]}
  logic [6:0] exp3_q[$];  // {cfg_ready3, tick3[2:0], sq3[2:0]}

  tickgen_multi #(.CHANNELS(2), .DIV_W(8), .DEFAULT_DIV(5)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .sync_clr  (sync_clr),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .tick      (tick),
    .sq        (sq)
  );

  tickgen_multi #(.CHANNELS(3), .DIV_W(8), .DEFAULT_DIV(5)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en3),
    .sync_clr  (sync_clr3),
    .cfg_valid (cfg_valid3),
    .cfg_ready (cfg_ready3),
    .cfg_ch    (cfg_ch3),
    .cfg_div   (cfg_div3),
    .tick      (tick3),
    .sq        (sq3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    en = '0; sync_clr = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
    en3 = '0; sync_clr3 = 1'b0; cfg_valid3 = 1'b0; cfg_ch3 = '0; cfg_div3 = '0;
  endtask

  // Leaves time at 1 unit after an edge with rst_n released; that interval is cycle 1.
  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    logic [4:0] e;
    logic [6:0] e3;
    idle_inputs();
    en = 2'b11; en3 = 3'b111; cfg_valid = 1'b1; cfg_valid3 = 1'b1;
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    exp_q.push_back(5'b1_00_00);
    exp3_q.push_back(7'b1_000_000);
    repeat (2) @(posedge clk);
    #4;
    e  = exp_q.pop_front();
    e3 = exp3_q.pop_front();
    vectors++; if (cfg_ready !== e[4]) begin miscompares++; $display("FAIL reset ready got=%b exp=%b", cfg_ready, e[4]); end
    vectors++; if (tick !== e[3:2]) begin miscompares++; $display("FAIL reset tick got=%b exp=%b", tick, e[3:2]); end
    vectors++; if (sq !== e[1:0]) begin miscompares++; $display("FAIL reset sq got=%b exp=%b", sq, e[1:0]); end
    vectors++; if (cfg_ready3 !== e3[6]) begin miscompares++; $display("FAIL reset ready3 got=%b exp=%b", cfg_ready3, e3[6]); end
    vectors++; if (tick3 !== e3[5:3]) begin miscompares++; $display("FAIL reset tick3 got=%b exp=%b", tick3, e3[5:3]); end
    vectors++; if (sq3 !== e3[2:0]) begin miscompares++; $display("FAIL reset sq3 got=%b exp=%b", sq3, e3[2:0]); end
  endtask

  // Channel 0 alone at the default divisor; channel 1 stays quiet.
  task automatic test_basic();
    logic [4:0] e;
    logic [1:0] es;
    logic       t0;
    do_reset();
    en = 2'b01;
    es = 2'b00;
    for (int c = 1; c <= 16; c++) begin
      t0 = (c == 5) || (c == 10) || (c == 15);
      exp_q.push_back({1'b1, 1'b0, t0, es});
      if (t0) es[0] = ~es[0];
    end
    for (int c = 1; c <= 16; c++) begin
      #4;
      e = exp_q.pop_front();
      vectors++; if (cfg_ready !== e[4]) begin miscompares++; $display("FAIL basic ready c=%0d got=%b exp=%b", c, cfg_ready, e[4]); end
      vectors++; if (tick !== e[3:2]) begin miscompares++; $display("FAIL basic tick c=%0d got=%b exp=%b", c, tick, e[3:2]); end
      vectors++; if (sq !== e[1:0]) begin miscompares++; $display("FAIL basic sq c=%0d got=%b exp=%b", c, sq, e[1:0]); end
      next_cycle();
    end
  endtask

  // Update to div=3 staged in cycle 7; cfg_valid stays high (div=7) while not ready.
  task automatic test_cfg_update();
    logic [4:0] e;
    logic [1:0] es;
    logic       t0;
    do_reset();
    en = 2'b01;
    es = 2'b00;
    for (int c = 1; c <= 20; c++) begin
      t0 = (c == 5) || (c == 10) || (c == 13) || (c == 16) || (c == 19);
      exp_q.push_back({!(c >= 8 && c <= 10), 1'b0, t0, es});
      if (t0) es[0] = ~es[0];
    end
    for (int c = 1; c <= 20; c++) begin
      cfg_valid = (c >= 7 && c <= 10);
      cfg_ch    = 1'b0;
      cfg_div   = (c == 7) ? 8'd3 : 8'd7;
      #4;
      e = exp_q.pop_front();
      vectors++; if (cfg_ready !== e[4]) begin miscompares++; $display("FAIL cfg_update ready c=%0d got=%b exp=%b", c, cfg_ready, e[4]); end
      vectors++; if (tick !== e[3:2]) begin miscompares++; $display("FAIL cfg_update tick c=%0d got=%b exp=%b", c, tick, e[3:2]); end
      vectors++; if (sq !== e[1:0]) begin miscompares++; $display("FAIL cfg_update sq c=%0d got=%b exp=%b", c, sq, e[1:0]); end
      next_cycle();
    end
    cfg_valid = 1'b0;
  endtask

  // div=0 on ch0 and div=1 on ch1 while disabled; enabled in cycles 3..9, then dropped.
  task automatic test_div_small();
    logic [4:0] e;
    logic [1:0] es;
    logic [1:0] enc;
    do_reset();
    es = 2'b00;
    for (int c = 1; c <= 12; c++) begin
      enc = (c >= 3 && c <= 9) ? 2'b11 : 2'b00;
      exp_q.push_back({1'b1, enc, es});
      es = (enc == 2'b11) ? ~es : 2'b00;
    end
    for (int c = 1; c <= 12; c++) begin
      en        = (c >= 3 && c <= 9) ? 2'b11 : 2'b00;
      cfg_valid = (c <= 2);
      cfg_ch    = (c >= 2) ? 1'b1 : 1'b0;
      cfg_div   = (c == 1) ? 8'd0 : 8'd1;
      #4;
      e = exp_q.pop_front();
      vectors++; if (cfg_ready !== e[4]) begin miscompares++; $display("FAIL div_small ready c=%0d got=%b exp=%b", c, cfg_ready, e[4]); end
      vectors++; if (tick !== e[3:2]) begin miscompares++; $display("FAIL div_small tick c=%0d got=%b exp=%b", c, tick, e[3:2]); end
      vectors++; if (sq !== e[1:0]) begin miscompares++; $display("FAIL div_small sq c=%0d got=%b exp=%b", c, sq, e[1:0]); end
      next_cycle();
    end
    cfg_valid = 1'b0;
  endtask

  // Divisors 4 and 6, enabled from cycle 4, sync_clr pulse in cycle 8.
  task automatic test_sync_clr();
    logic [4:0] e;
    logic [1:0] es;
    logic       t0, t1;
    do_reset();
    es = 2'b00;
    for (int c = 1; c <= 20; c++) begin
      t0 = (c == 7) || (c == 12) || (c == 16) || (c == 20);
      t1 = (c == 14) || (c == 20);
      exp_q.push_back({1'b1, t1, t0, es});
      es = (c == 8) ? 2'b00 : (es ^ {t1, t0});
    end
    for (int c = 1; c <= 20; c++) begin
      en        = (c >= 4) ? 2'b11 : 2'b00;
      sync_clr  = (c == 8);
      cfg_valid = (c <= 2);
      cfg_ch    = (c >= 2) ? 1'b1 : 1'b0;
      cfg_div   = (c == 1) ? 8'd4 : 8'd6;
      #4;
      e = exp_q.pop_front();
      vectors++; if (cfg_ready !== e[4]) begin miscompares++; $display("FAIL sync_clr ready c=%0d got=%b exp=%b", c, cfg_ready, e[4]); end
      vectors++; if (tick !== e[3:2]) begin miscompares++; $display("FAIL sync_clr tick c=%0d got=%b exp=%b", c, tick, e[3:2]); end
      vectors++; if (sq !== e[1:0]) begin miscompares++; $display("FAIL sync_clr sq c=%0d got=%b exp=%b", c, sq, e[1:0]); end
      next_cycle();
    end
    sync_clr  = 1'b0;
    cfg_valid = 1'b0;
  endtask

  // Three-channel instance: cfg_ch=3 names no channel and must change nothing.
  task automatic test_out_of_range();
    logic [6:0] e3;
    logic [2:0] es;
    logic       tc;
    do_reset();
    en3 = 3'b111;
    es  = 3'b000;
    for (int c = 1; c <= 16; c++) begin
      tc = (c == 5) || (c == 10) || (c == 15);
      exp3_q.push_back({1'b1, {3{tc}}, es});
      if (tc) es = ~es;
    end
    for (int c = 1; c <= 16; c++) begin
      cfg_valid3 = (c == 2) || (c == 3);
      cfg_ch3    = 2'd3;
      cfg_div3   = 8'd2;
      #4;
      e3 = exp3_q.pop_front();
      vectors++; if (cfg_ready3 !== e3[6]) begin miscompares++; $display("FAIL out_of_range ready c=%0d got=%b exp=%b", c, cfg_ready3, e3[6]); end
      vectors++; if (tick3 !== e3[5:3]) begin miscompares++; $display("FAIL out_of_range tick c=%0d got=%b exp=%b", c, tick3, e3[5:3]); end
      vectors++; if (sq3 !== e3[2:0]) begin miscompares++; $display("FAIL out_of_range sq c=%0d got=%b exp=%b", c, sq3, e3[2:0]); end
      next_cycle();
    end
    cfg_valid3 = 1'b0;
  endtask

  // Pending div=3 on ch0, reset dropped mid-cycle 10; the staged divisor must be lost.
  task automatic test_reset_pending();
    logic [4:0] e;
    logic [1:0] es;
    logic       t0;
    do_reset();
    en = 2'b01;
    es = 2'b00;
    for (int c = 1; c <= 10; c++) begin
      t0 = (c == 5) || (c == 10);
      exp_q.push_back({!(c >= 8), 1'b0, t0, es});
      if (t0) es[0] = ~es[0];
    end
    for (int c = 1; c <= 10; c++) begin
      cfg_valid = (c == 7);
      cfg_ch    = 1'b0;
      cfg_div   = 8'd3;
      #4;
      e = exp_q.pop_front();
      vectors++; if (cfg_ready !== e[4]) begin miscompares++; $display("FAIL rst_pend ready c=%0d got=%b exp=%b", c, cfg_ready, e[4]); end
      vectors++; if (tick !== e[3:2]) begin miscompares++; $display("FAIL rst_pend tick c=%0d got=%b exp=%b", c, tick, e[3:2]); end
      vectors++; if (sq !== e[1:0]) begin miscompares++; $display("FAIL rst_pend sq c=%0d got=%b exp=%b", c, sq, e[1:0]); end
      if (c < 10) next_cycle();
    end
    rst_n = 1'b0;
    exp_q.push_back(5'b1_00_00);
    #1;
    e = exp_q.pop_front();
    vectors++; if (cfg_ready !== e[4]) begin miscompares++; $display("FAIL async_rst ready got=%b exp=%b", cfg_ready, e[4]); end
    vectors++; if (tick !== e[3:2]) begin miscompares++; $display("FAIL async_rst tick got=%b exp=%b", tick, e[3:2]); end
    vectors++; if (sq !== e[1:0]) begin miscompares++; $display("FAIL async_rst sq got=%b exp=%b", sq, e[1:0]); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 1;
    es    = 2'b00;
    for (int c = 1; c <= 12; c++) begin
      t0 = (c == 5) || (c == 10);
      exp_q.push_back({1'b1, 1'b0, t0, es});
      if (t0) es[0] = ~es[0];
    end
    for (int c = 1; c <= 12; c++) begin
      #4;
      e = exp_q.pop_front();
      vectors++; if (cfg_ready !== e[4]) begin miscompares++; $display("FAIL post_rst ready c=%0d got=%b exp=%b", c, cfg_ready, e[4]); end
      vectors++; if (tick !== e[3:2]) begin miscompares++; $display("FAIL post_rst tick c=%0d got=%b exp=%b", c, tick, e[3:2]); end
      vectors++; if (sq !== e[1:0]) begin miscompares++; $display("FAIL post_rst sq c=%0d got=%b exp=%b", c, sq, e[1:0]); end
      next_cycle();
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    test_reset();
    test_basic();
    test_cfg_update();
    test_div_small();
    test_sync_clr();
    test_out_of_range();
    test_reset_pending();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
